// File: rtl/spi_pkg.sv
// Shared SPI definitions: controller state encoding, clock-mode encoding and default field widths.
package spi_pkg;

    localparam int unsigned SPI_DIV_W = 8;
    localparam int unsigned SPI_CNT_W = 6;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } spi_state_e;

    // {cpol, cpha} as in the usual SPI mode numbering
    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // Leading edges sample in CPHA=0, trailing edges sample in CPHA=1.
    function automatic logic is_sample_edge(input spi_mode_t mode, input logic leading);
        return leading ^ mode.cpha;
    endfunction

endpackage

// File: rtl/spi_sclk_gen_if.sv
// Config/start handshake and SCLK/strobe outputs between the SPI controller and the clock generator.
interface spi_sclk_gen_if #(
    parameter int unsigned DIV_W = spi_pkg::SPI_DIV_W,
    parameter int unsigned CNT_W = spi_pkg::SPI_CNT_W
);
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_pulses;
    logic             cfg_cpol;
    logic             cfg_cpha;
    logic             start_n;
    logic             abort;
    logic             idle;
    logic             sclk;
    logic             sample;
    logic             shift;
    logic             done;
    logic [CNT_W-1:0] pulse_cnt;

    modport master (
        output cfg_valid, cfg_div, cfg_pulses, cfg_cpol, cfg_cpha, start_n, abort,
        input  idle, sclk, sample, shift, done, pulse_cnt
    );

    modport slave (
        input  cfg_valid, cfg_div, cfg_pulses, cfg_cpol, cfg_cpha, start_n, abort,
        output idle, sclk, sample, shift, done, pulse_cnt
    );

endinterface

// File: rtl/spi_edge_timer.sv
// Half-period counter: runs 0..div while enabled and flags the terminal count; held at 0 otherwise.
module spi_edge_timer #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == div);

    always_comb begin
        cnt_d = '0;
        if (en && !tick) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_sclk_gen.sv
// SPI SCLK burst generator: N pulses at a programmable half-period in any CPOL/CPHA mode,
// with single-cycle sample/shift strobes aligned to the registered SCLK edges.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int unsigned DIV_W          = SPI_DIV_W,
    parameter int unsigned CNT_W          = SPI_CNT_W,
    parameter int unsigned DEFAULT_DIV    = 1,
    parameter int unsigned DEFAULT_PULSES = 8
) (
    input logic           clk,
    input logic           rst_n,
    spi_sclk_gen_if.slave bus
);

    spi_state_e       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pulses_q, pulses_d;
    spi_mode_t        mode_q, mode_d;
    logic [CNT_W:0]   edge_q, edge_d;
    logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
    logic             sclk_q, sclk_d;
    logic             sample_q, sample_d;
    logic             shift_q, shift_d;
    logic             done_q, done_d;
    logic             idle_q, idle_d;

    logic tick, run_en, start_go, leading, last_edge, samp_edge;

    spi_edge_timer #(
        .DIV_W(DIV_W)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (run_en),
        .div  (div_q),
        .tick (tick)
    );

    assign run_en    = (state_q == StRun);
    assign start_go  = (state_q == StIdle) && !bus.cfg_valid && !bus.start_n;
    assign leading   = ~edge_q[0];
    assign last_edge = (edge_q == ({pulses_q, 1'b0} - (CNT_W + 1)'(1)));
    assign samp_edge = is_sample_edge(mode_q, leading);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_go) begin
                    state_d = (pulses_q == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (tick && last_edge) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        div_d       = div_q;
        pulses_d    = pulses_q;
        mode_d      = mode_q;
        edge_d      = edge_q;
        pulse_cnt_d = pulse_cnt_q;
        sample_d    = 1'b0;
        shift_d     = 1'b0;

        if ((state_q == StIdle) && bus.cfg_valid) begin
            div_d       = bus.cfg_div;
            pulses_d    = bus.cfg_pulses;
            mode_d.cpol = bus.cfg_cpol;
            mode_d.cpha = bus.cfg_cpha;
        end

        // CPHA=0 launches the first bit as the burst begins, before any SCLK edge
        if (start_go) begin
            edge_d      = '0;
            pulse_cnt_d = '0;
            shift_d     = (pulses_q != '0) && !mode_q.cpha;
        end

        if (run_en && !bus.abort && tick) begin
            edge_d = edge_q + (CNT_W + 1)'(1);
            if (!leading) begin
                pulse_cnt_d = pulse_cnt_q + CNT_W'(1);
            end
            sample_d = samp_edge;
            shift_d  = !samp_edge && !last_edge;
        end

        sclk_d = (state_d == StRun) ? (sclk_q ^ (run_en && tick)) : mode_d.cpol;
        done_d = (state_d == StDone);
        idle_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= DIV_W'(DEFAULT_DIV);
            pulses_q    <= CNT_W'(DEFAULT_PULSES);
            mode_q      <= '0;
            edge_q      <= '0;
            pulse_cnt_q <= '0;
            sclk_q      <= 1'b0;
            sample_q    <= 1'b0;
            shift_q     <= 1'b0;
            done_q      <= 1'b0;
            idle_q      <= 1'b1;
        end else begin
            div_q       <= div_d;
            pulses_q    <= pulses_d;
            mode_q      <= mode_d;
            edge_q      <= edge_d;
            pulse_cnt_q <= pulse_cnt_d;
            sclk_q      <= sclk_d;
            sample_q    <= sample_d;
            shift_q     <= shift_d;
            done_q      <= done_d;
            idle_q      <= idle_d;
        end
    end

    assign bus.idle      = idle_q;
    assign bus.sclk      = sclk_q;
    assign bus.sample    = sample_q;
    assign bus.shift     = shift_q;
    assign bus.done      = done_q;
    assign bus.pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Bench for spi_sclk_gen: burst-timeline reference model checked every cycle, directed scenarios
// with hand-computed expectations, then randomized traffic.
module tb_spi_sclk_gen;

    localparam int DW = 8;
    localparam int CW = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    spi_sclk_gen_if #(.DIV_W(DW), .CNT_W(CW)) bus ();

    spi_sclk_gen #(
        .DIV_W         (DW),
        .CNT_W         (CW),
        .DEFAULT_DIV   (1),
        .DEFAULT_PULSES(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: phase (0 idle, 1 running, 2 done), cycles elapsed since the burst began, config.
    int m_ph = 0, m_k = 0, m_div = 1, m_n = 8, m_cpol = 0, m_cpha = 0, m_p = 0;
    int cnt, ed, e_idle, e_sclk, e_samp, e_shift, e_done;
    logic [CW+4:0] act_v, exp_v;

    // Monitor totals, only written by the compare process
    int tot_sample = 0, tot_shift = 0, tot_done = 0, tot_busy = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Compare on the falling edge, then advance the model with the inputs the next rising edge sees.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            m_ph = 0; m_k = 0; m_div = 1; m_n = 8; m_cpol = 0; m_cpha = 0; m_p = 0;
        end else begin
            cnt = (m_ph == 1) ? m_k / (m_div + 1) : 0;
            ed = 0;
            if (m_ph == 1 && m_k > 0 && (m_k % (m_div + 1)) == 0) ed = cnt;
            if (m_ph == 2 && m_n > 0) ed = 2 * m_n;
            e_idle  = (m_ph == 0) ? 1 : 0;
            e_done  = (m_ph == 2) ? 1 : 0;
            e_sclk  = (m_ph == 1) ? (m_cpol ^ (cnt % 2)) : m_cpol;
            e_samp  = (ed != 0 && ((m_cpha == 1) ? (ed % 2 == 0) : (ed % 2 == 1))) ? 1 : 0;
            e_shift = 0;
            if (ed != 0) begin
                if (m_cpha == 1) e_shift = (ed % 2 == 1) ? 1 : 0;
                else e_shift = (ed % 2 == 0 && ed != 2 * m_n) ? 1 : 0;
            end
            if (m_ph == 1 && m_k == 0 && m_cpha == 0) e_shift = 1;
            exp_v = {1'(e_idle), 1'(e_sclk), 1'(e_samp), 1'(e_shift), 1'(e_done), CW'(m_p)};
            act_v = {bus.idle, bus.sclk, bus.sample, bus.shift, bus.done, bus.pulse_cnt};
            n_checks++;
            if (act_v !== exp_v) begin
                n_errors++;
                $display("FAIL cycle_model @%0t: {idle,sclk,sample,shift,done,cnt} got %h, expected %h",
                         $time, act_v, exp_v);
            end
            tot_sample += int'(bus.sample);
            tot_shift  += int'(bus.shift);
            tot_done   += int'(bus.done);
            tot_busy   += (!bus.idle && !bus.done) ? 1 : 0;

            case (m_ph)
                0: begin
                    if (bus.cfg_valid) begin
                        m_div  = int'(bus.cfg_div);
                        m_n    = int'(bus.cfg_pulses);
                        m_cpol = int'(bus.cfg_cpol);
                        m_cpha = int'(bus.cfg_cpha);
                    end else if (!bus.start_n) begin
                        m_p  = 0;
                        m_k  = 0;
                        m_ph = (m_n == 0) ? 2 : 1;
                    end
                end
                1: begin
                    if (bus.abort) begin
                        m_ph = 0;
                    end else begin
                        m_k++;
                        if (m_k == 2 * m_n * (m_div + 1)) m_ph = 2;
                    end
                end
                default: m_ph = 0;
            endcase
            if (m_ph == 1) m_p = (m_k / (m_div + 1)) / 2;
            else if (m_ph == 2) m_p = m_n;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input int d, input int p, input int cpol, input int cpha);
        bus.cfg_valid  = 1'b1;
        bus.cfg_div    = DW'(d);
        bus.cfg_pulses = CW'(p);
        bus.cfg_cpol   = 1'(cpol);
        bus.cfg_cpha   = 1'(cpha);
        step();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic do_start();
        bus.start_n = 1'b0;
        step();
        bus.start_n = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!bus.idle && n < 2000) begin
            step();
            n++;
        end
        if (n >= 2000) chk({name, "_timeout"}, int'(bus.idle), 1);
    endtask

    int b_samp, b_shift, b_done, b_busy;

    task automatic snap();
        b_samp  = tot_sample;
        b_shift = tot_shift;
        b_done  = tot_done;
        b_busy  = tot_busy;
    endtask

    initial begin
        bus.cfg_valid  = 1'b0;
        bus.cfg_div    = '0;
        bus.cfg_pulses = '0;
        bus.cfg_cpol   = 1'b0;
        bus.cfg_cpha   = 1'b0;
        bus.start_n    = 1'b1;
        bus.abort      = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        chk("rst_idle", int'(bus.idle), 1);
        chk("rst_sclk", int'(bus.sclk), 0);
        chk("rst_cnt", int'(bus.pulse_cnt), 0);
        chk("rst_done", int'(bus.done), 0);

        // Mode 0, div=1, 8 pulses
        do_cfg(1, 8, 0, 0);
        snap();
        do_start();
        chk("m0_entry_shift", int'(bus.shift), 1);
        chk("m0_entry_sclk", int'(bus.sclk), 0);
        step();
        chk("m0_k1_sclk", int'(bus.sclk), 0);
        step();
        chk("m0_first_rise", int'(bus.sclk), 1);
        chk("m0_first_sample", int'(bus.sample), 1);
        wait_idle("m0");
        chk("m0_run_cycles", tot_busy - b_busy, 32);
        chk("m0_samples", tot_sample - b_samp, 8);
        chk("m0_shifts", tot_shift - b_shift, 8);
        chk("m0_done", tot_done - b_done, 1);
        chk("m0_cnt", int'(bus.pulse_cnt), 8);
        chk("m0_sclk_end", int'(bus.sclk), 0);

        // Mode 3, div=0, 4 pulses
        do_cfg(0, 4, 1, 1);
        chk("m3_idle_level", int'(bus.sclk), 1);
        snap();
        do_start();
        chk("m3_entry_sclk", int'(bus.sclk), 1);
        step();
        chk("m3_fall", int'(bus.sclk), 0);
        chk("m3_fall_shift", int'(bus.shift), 1);
        step();
        chk("m3_rise_sample", int'(bus.sample), 1);
        wait_idle("m3");
        chk("m3_run_cycles", tot_busy - b_busy, 8);
        chk("m3_samples", tot_sample - b_samp, 4);
        chk("m3_shifts", tot_shift - b_shift, 4);
        chk("m3_sclk_end", int'(bus.sclk), 1);

        // cfg and start in the same cycle: cfg wins, start takes effect next cycle
        bus.cfg_valid  = 1'b1;
        bus.cfg_div    = DW'(3);
        bus.cfg_pulses = CW'(2);
        bus.cfg_cpol   = 1'b0;
        bus.cfg_cpha   = 1'b0;
        bus.start_n    = 1'b0;
        snap();
        step();
        bus.cfg_valid = 1'b0;
        chk("prio_still_idle", int'(bus.idle), 1);
        step();
        bus.start_n = 1'b1;
        chk("prio_started", int'(bus.idle), 0);
        step();
        do_cfg(0, 2, 0, 0);
        wait_idle("prio");
        chk("prio_run_cycles", tot_busy - b_busy, 16);
        snap();
        do_start();
        wait_idle("cfg_in_run");
        chk("cfg_in_run_ignored", tot_busy - b_busy, 16);

        // Empty burst
        do_cfg(2, 0, 0, 0);
        snap();
        do_start();
        chk("empty_done", int'(bus.done), 1);
        chk("empty_cnt", int'(bus.pulse_cnt), 0);
        step();
        chk("empty_back_idle", int'(bus.idle), 1);
        chk("empty_strobes", (tot_sample - b_samp) + (tot_shift - b_shift), 0);

        // Abort after 3 pulses
        do_cfg(1, 8, 0, 0);
        snap();
        do_start();
        for (int n = 0; n < 200 && bus.pulse_cnt != CW'(3); n++) step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_sclk", int'(bus.sclk), 0);
        chk("abort_idle", int'(bus.idle), 1);
        repeat (3) step();
        chk("abort_no_done", tot_done - b_done, 0);
        chk("abort_cnt", int'(bus.pulse_cnt), 3);

        // Reset mid-burst in mode 2
        do_cfg(4, 8, 1, 0);
        do_start();
        repeat (7) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_sclk", int'(bus.sclk), 0);
        chk("rst_mid_idle", int'(bus.idle), 1);
        step();
        rst_n = 1'b1;
        step();
        snap();
        do_start();
        wait_idle("rst_defaults");
        chk("rst_default_run", tot_busy - b_busy, 32);
        chk("rst_default_cnt", int'(bus.pulse_cnt), 8);
        chk("rst_default_done", tot_done - b_done, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bus.cfg_valid  = ($urandom_range(7) == 0);
            bus.cfg_div    = DW'($urandom_range(3));
            bus.cfg_pulses = CW'($urandom_range(6));
            bus.cfg_cpol   = 1'($urandom_range(1));
            bus.cfg_cpha   = 1'($urandom_range(1));
            bus.start_n    = ($urandom_range(3) != 0);
            bus.abort      = ($urandom_range(39) == 0);
            step();
        end
        bus.cfg_valid = 1'b0;
        bus.start_n   = 1'b1;
        bus.abort     = 1'b0;
        wait_idle("rand_drain");
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_sclk_gen.md
Name: spi_sclk_gen

Overview:
- Parametrised SPI serial-clock generator.
- Produces a finite burst of N SCLK pulses at a programmable rate, in any of the four CPOL/CPHA modes.
- Also produces single-cycle sample/shift strobes in the i_clk domain, so the SPI shift register can run without a second clock.
- Sits between the SPI controller FSM (config, start, done) and the SPI shift datapath and pads.

Parameters:
- DIV_W, 8: width of the half-period divisor.
- CNT_W, 6: width of the pulse-count field and counter.
- DEFAULT_DIV, 1: divisor value after reset.
- DEFAULT_PULSES, 8: pulse count after reset.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_cfg_valid  in  1  load the i_cfg_* fields; honoured only in IDLE.
- i_cfg_div  in  DIV_W  SCLK half-period = i_cfg_div+1 i_clk cycles.
- i_cfg_pulses  in  CNT_W  SCLK pulses per burst; 0 = empty burst.
- i_cfg_cpol  in  1  SCLK idle level.
- i_cfg_cpha  in  1  0 = sample on leading edge; 1 = sample on trailing edge.
- i_start_n  in  1  active-low start, level-sampled in IDLE.
- i_abort  in  1  terminate the burst; honoured in RUN.
- o_idle  out  1  high in IDLE.
- o_sclk  out  1  registered SCLK.
- o_sample  out  1  one-cycle strobe on each sampling edge.
- o_shift  out  1  one-cycle strobe on each launch point.
- o_done  out  1  one-cycle pulse at normal burst completion.
- o_pulse_cnt  out  CNT_W  pulses completed in the current or last burst.

Behaviour:
- Reset (async):
  - State = IDLE.
  - Config registers: div=DEFAULT_DIV, pulses=DEFAULT_PULSES, cpol=0, cpha=0.
  - Outputs: o_sclk=0, o_sample=0, o_shift=0, o_done=0, o_pulse_cnt=0, o_idle=1.
  - Internal counters = 0.
- All outputs are registered; there are no combinational paths from input to output.
- States: IDLE, RUN, DONE.
- IDLE:
  - o_sclk = cpol register. A cfg write that changes CPOL moves o_sclk on the next cycle.
  - i_cfg_valid=1: latch all fields. i_cfg_valid has priority, so i_start_n is ignored that cycle.
  - Otherwise, i_start_n=0: zero the half counter and o_pulse_cnt, then go to RUN.
  - Exception: if pulses=0, go to DONE directly; no SCLK edges and no strobes are produced.
- RUN:
  - Half counter runs 0..div.
  - At terminal count: toggle o_sclk, clear the half counter, count one edge.
  - The first toggle is registered div+1 cycles after RUN entry.
  - Edges alternate leading/trailing. There are 2*N edges in total.
  - o_pulse_cnt increments with each trailing edge.
  - After the 2N-th edge, go to DONE. o_sclk is back at CPOL.
  - RUN lasts exactly 2*N*(div+1) cycles.
  - cfg writes and start are ignored in RUN.
- Strobes, asserted in the same cycle the corresponding o_sclk edge becomes visible:
  - CPHA=0: o_sample on every leading edge. o_shift in the first RUN cycle, then on each trailing edge except the last.
  - CPHA=1: o_shift on every leading edge. o_sample on every trailing edge.
  - Either mode: exactly N o_sample and N o_shift pulses per burst.
- DONE: o_done=1 for one cycle, o_idle=0, then go to IDLE. o_pulse_cnt holds its value until the next start.
- Abort:
  - i_abort=1 in RUN: next cycle o_sclk=CPOL, strobes=0, state=IDLE.
  - No o_done pulse. o_pulse_cnt holds the partial count.
  - Abort in the same cycle as the final edge: abort wins.
- o_idle = 0 in RUN and DONE.
- Reset asserted mid-burst: immediate return to the reset values above. No done pulse.
- div=0 gives SCLK = f_clk/2, with one edge every cycle.
- Counter widths:
  - Half counter is DIV_W bits.
  - Edge counter is CNT_W+1 bits, so 2*(2^CNT_W - 1) does not overflow.
  - No wrap-around is permitted.

Decomposition:
- Shared package spi_pkg holds:
  - state encodings IDLE/RUN/DONE;
  - the mode encoding {cpol,cpha};
  - widths DIV_W and CNT_W used by the SPI controller.
- One natural sub-module: spi_edge_timer.
  - Contains the half-period counter plus the terminal-count tick.
  - Its inputs are div and enable; its output is tick.
  - The FSM and strobe logic stay in spi_sclk_gen.

Test Plan:
- Mode 0, div=1, pulses=8, start held low 1 cycle:
  - SCLK period is 4 cycles; RUN lasts 32 cycles.
  - First rising edge 2 cycles after RUN entry.
  - 8 o_sample on rising edges; 8 o_shift, the first in the RUN-entry cycle.
  - o_done exactly once; o_pulse_cnt=8; o_sclk ends at 0.
- Mode 3, div=0, pulses=4:
  - Idle level is 1; SCLK toggles every cycle for 8 cycles.
  - o_shift on the falling edges, o_sample on the rising edges; o_sclk returns to 1.
- i_cfg_valid and i_start_n=0 in the same IDLE cycle with a new div=3:
  - Config is latched and start is ignored that cycle.
  - Burst starts next cycle with half-period 4.
  - A cfg write during RUN leaves div unchanged.
- pulses=0 and start:
  - o_done pulses 1 cycle after start; no SCLK edges, no strobes; o_pulse_cnt=0.
- Abort after 3 pulses of an 8-pulse burst:
  - Next cycle o_sclk=CPOL and o_idle=1; no o_done; o_pulse_cnt=3.
- i_rst_n low mid-burst (mode 2):
  - o_sclk=0 and o_idle=1 immediately; config returns to div=1, pulses=8.
